// File: rtl/servo_frame_scheduler_pkg.sv
// Shared definitions for the servo frame scheduler: FSM encodings, frame length,
// neutral setpoint and the elaboration-time edge-placement check.
package servo_sched_pkg;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t ST_IDLE    = 2'd0;
    localparam sched_state_t ST_STAGGER = 2'd1;
    localparam sched_state_t ST_RUN     = 2'd2;
    localparam sched_state_t ST_DRAIN   = 2'd3;

    localparam int FRAME_US     = 20000;
    localparam int INIT_HALF_US = 500;

    function automatic int frame_cycles(input int freq_mhz);
        return FRAME_US * freq_mhz;
    endfunction

    function automatic int neutral_value(input int max_in);
        return max_in / 2;
    endfunction

    // Every lane update must land inside the generators' 0.5 ms init phase.
    function automatic bit glitch_free_ok(input int num_ch, input int stagger_cyc,
                                          input int freq_mhz);
        return (num_ch * stagger_cyc + num_ch) < (INIT_HALF_US * freq_mhz);
    endfunction

endpackage

// File: rtl/servo_frame_scheduler_slew_step.sv
// One slew step: moves an active setpoint toward its target by at most SLEW
// (SLEW = 0 jumps straight to target). Shared by the sequential update sweep.
module servo_slew_step #(
    parameter int W    = 8,
    parameter int SLEW = 4
) (
    input  logic [W-1:0] active_i,
    input  logic [W-1:0] target_i,
    output logic [W-1:0] next_o
);

    localparam logic [W-1:0] STEP = W'(SLEW);

    logic [W-1:0] diff;

    always_comb begin
        next_o = target_i;
        diff   = '0;
        if (SLEW != 0) begin
            if (target_i >= active_i) begin
                diff = target_i - active_i;
                if (diff > STEP) begin
                    next_o = active_i + STEP;
                end
            end else begin
                diff = active_i - target_i;
                if (diff > STEP) begin
                    next_o = active_i - STEP;
                end
            end
        end
    end

endmodule

// File: rtl/servo_frame_scheduler.sv
// Frame scheduler for a bank of servo PWM generators: owns the shadow/target/active
// setpoint tables, commits on frame ticks, slew-limits and staggers the enables.
module servo_frame_scheduler
    import servo_sched_pkg::*;
#(
    parameter int C_NUM_CH      = 18,
    parameter int C_PWM_SIZE    = 8,
    parameter int C_PWM_FREQ    = 100,
    parameter int C_PWM_MAX_IN  = 200,
    parameter int C_STAGGER_CYC = 1000,
    parameter int C_SLEW        = 4
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic                           GLOBAL_EN,
    input  logic                           WR_VALID,
    output logic                           WR_READY,
    input  logic [$clog2(C_NUM_CH)-1:0]    WR_CH,
    input  logic [C_PWM_SIZE-1:0]          WR_DATA,
    input  logic                           COMMIT,
    output logic                           WR_ERR,
    output logic [C_NUM_CH-1:0]            EN_OUT,
    output logic [C_NUM_CH*C_PWM_SIZE-1:0] PWM_BUS,
    output logic                           FRAME_TICK,
    output logic                           PENDING,
    output logic [1:0]                     DBG_STATE
);

    localparam int C_FRAME = frame_cycles(C_PWM_FREQ);
    localparam int CNT_W   = $clog2(C_FRAME);
    localparam int CH_W    = $clog2(C_NUM_CH);
    localparam int W       = C_PWM_SIZE;

    localparam logic [W-1:0]     NEUTRAL    = W'(neutral_value(C_PWM_MAX_IN));
    localparam logic [W-1:0]     MAX_IN     = W'(C_PWM_MAX_IN);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(C_FRAME - 1);
    localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(C_NUM_CH - 1);

    if (!glitch_free_ok(C_NUM_CH, C_STAGGER_CYC, C_PWM_FREQ)) begin : g_glitch_check
        $error("servo_frame_scheduler: stagger plus sweep does not fit in the init phase");
    end

    sched_state_t         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_next;
    logic [CNT_W-1:0]     drain_q, drain_d;
    logic [C_NUM_CH-1:0]  en_q, en_d;
    logic                 pending_q, pending_d;
    logic                 wr_err_q, wr_err_d;
    logic                 swp_busy_q, swp_busy_d;
    logic [CH_W-1:0]      swp_idx_q, swp_idx_d;

    logic [W-1:0] shadow_q [0:C_NUM_CH-1];
    logic [W-1:0] shadow_d [0:C_NUM_CH-1];
    logic [W-1:0] target_q [0:C_NUM_CH-1];
    logic [W-1:0] target_d [0:C_NUM_CH-1];
    logic [W-1:0] active_q [0:C_NUM_CH-1];
    logic [W-1:0] active_d [0:C_NUM_CH-1];

    logic         frame_tick;
    logic         wr_ready;
    logic         wr_fire;
    logic [W-1:0] wr_data_sat;
    logic [W-1:0] slew_next;

    // Write handshake: a write is taken in any cycle where WR_VALID and WR_READY are both
    // high; WR_READY is combinational from state only and never looks at WR_VALID.
    assign frame_tick  = (state_q != ST_IDLE) && (cnt_q == '0);
    assign wr_ready    = !(frame_tick || swp_busy_q);
    assign wr_fire     = WR_VALID && wr_ready;
    assign wr_data_sat = (WR_DATA > MAX_IN) ? MAX_IN : WR_DATA;
    assign cnt_next    = (cnt_q == FRAME_LAST) ? '0 : cnt_q + CNT_W'(1);

    servo_slew_step #(
        .W    (W),
        .SLEW (C_SLEW)
    ) u_slew (
        .active_i (active_q[swp_idx_q]),
        .target_i (target_q[swp_idx_q]),
        .next_o   (slew_next)
    );

    // Run-state FSM, frame counter and enable stagger.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        en_d    = en_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                drain_d = '0;
                en_d    = '0;
                if (GLOBAL_EN) begin
                    state_d = ST_STAGGER;
                    en_d[0] = 1'b1;
                end
            end
            ST_STAGGER: begin
                cnt_d = cnt_next;
                if (!GLOBAL_EN) begin
                    state_d = ST_DRAIN;
                    en_d    = '0;
                    drain_d = '0;
                end else begin
                    for (int i = 1; i < C_NUM_CH; i++) begin
                        if (cnt_next == CNT_W'(i * C_STAGGER_CYC)) begin
                            en_d[i] = 1'b1;
                        end
                    end
                    if (&en_q) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_next;
                en_d  = '1;
                if (!GLOBAL_EN) begin
                    state_d = ST_DRAIN;
                    en_d    = '0;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_next;
                en_d  = '0;
                if (drain_q == FRAME_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                drain_d = '0;
                en_d    = '0;
            end
        endcase
    end

    // Tables, commit and the one-channel-per-cycle update sweep.
    always_comb begin
        shadow_d   = shadow_q;
        target_d   = target_q;
        active_d   = active_q;
        pending_d  = COMMIT || (pending_q && !frame_tick);
        wr_err_d   = wr_fire && (int'(WR_CH) >= C_NUM_CH);
        swp_busy_d = swp_busy_q;
        swp_idx_d  = swp_idx_q;

        for (int i = 0; i < C_NUM_CH; i++) begin
            if (wr_fire && (WR_CH == CH_W'(i))) begin
                shadow_d[i] = wr_data_sat;
            end
        end

        if (frame_tick && pending_q) begin
            target_d = shadow_q;
        end

        // Channel i is stepped in cycle tick+1+i, so the sweep reads the fresh target.
        if (frame_tick) begin
            swp_busy_d = 1'b1;
            swp_idx_d  = '0;
        end else if (swp_busy_q) begin
            active_d[swp_idx_q] = slew_next;
            if (swp_idx_q == LAST_CH) begin
                swp_busy_d = 1'b0;
                swp_idx_d  = '0;
            end else begin
                swp_idx_d = swp_idx_q + CH_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            drain_q    <= '0;
            en_q       <= '0;
            pending_q  <= 1'b0;
            wr_err_q   <= 1'b0;
            swp_busy_q <= 1'b0;
            swp_idx_q  <= '0;
            for (int i = 0; i < C_NUM_CH; i++) begin
                shadow_q[i] <= NEUTRAL;
                target_q[i] <= NEUTRAL;
                active_q[i] <= NEUTRAL;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            en_q       <= en_d;
            pending_q  <= pending_d;
            wr_err_q   <= wr_err_d;
            swp_busy_q <= swp_busy_d;
            swp_idx_q  <= swp_idx_d;
            shadow_q   <= shadow_d;
            target_q   <= target_d;
            active_q   <= active_d;
        end
    end

    always_comb begin
        PWM_BUS = '0;
        for (int i = 0; i < C_NUM_CH; i++) begin
            PWM_BUS[i*W +: W] = active_q[i];
        end
    end

    assign WR_READY   = wr_ready;
    assign WR_ERR     = wr_err_q;
    assign EN_OUT     = en_q;
    assign FRAME_TICK = frame_tick;
    assign PENDING    = pending_q;
    assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Directed bench for servo_frame_scheduler: two instances share stimulus, one slew
// limited (4) and one unlimited (0) so committed targets are directly visible.
`timescale 1ns/1ps
module tb_servo_frame_scheduler;

    localparam int N     = 5;
    localparam int W     = 8;
    localparam int FRAME = 20000;
    localparam int STAG  = 10;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_STAGGER = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    localparam logic [N*W-1:0] NEUTRAL_BUS = {N{8'd100}};

    logic           clk = 1'b0;
    logic           rst;
    logic           global_en;
    logic           wr_valid;
    logic [2:0]     wr_ch;
    logic [W-1:0]   wr_data;
    logic           commit;

    logic           wr_ready,   wr_ready_z;
    logic           wr_err,     wr_err_z;
    logic [N-1:0]   en_out,     en_out_z;
    logic [N*W-1:0] pwm_bus,    pwm_bus_z;
    logic           frame_tick, frame_tick_z;
    logic           pending,    pending_z;
    logic [1:0]     state,      state_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    servo_frame_scheduler #(
        .C_NUM_CH(N), .C_PWM_SIZE(W), .C_PWM_FREQ(1), .C_PWM_MAX_IN(200),
        .C_STAGGER_CYC(STAG), .C_SLEW(4)
    ) dut (
        .CLK(clk), .nRST(rst), .GLOBAL_EN(global_en), .WR_VALID(wr_valid),
        .WR_READY(wr_ready), .WR_CH(wr_ch), .WR_DATA(wr_data), .COMMIT(commit),
        .WR_ERR(wr_err), .EN_OUT(en_out), .PWM_BUS(pwm_bus), .FRAME_TICK(frame_tick),
        .PENDING(pending), .DBG_STATE(state)
    );

    servo_frame_scheduler #(
        .C_NUM_CH(N), .C_PWM_SIZE(W), .C_PWM_FREQ(1), .C_PWM_MAX_IN(200),
        .C_STAGGER_CYC(STAG), .C_SLEW(0)
    ) dut_z (
        .CLK(clk), .nRST(rst), .GLOBAL_EN(global_en), .WR_VALID(wr_valid),
        .WR_READY(wr_ready_z), .WR_CH(wr_ch), .WR_DATA(wr_data), .COMMIT(commit),
        .WR_ERR(wr_err_z), .EN_OUT(en_out_z), .PWM_BUS(pwm_bus_z), .FRAME_TICK(frame_tick_z),
        .PENDING(pending_z), .DBG_STATE(state_z)
    );

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] ch, input logic [W-1:0] data, input logic com);
        wr_valid = 1'b1;
        wr_ch    = ch;
        wr_data  = data;
        commit   = com;
        tick_clk();
        wr_valid = 1'b0;
        commit   = 1'b0;
    endtask

    function automatic logic [N*W-1:0] pack5(input int a0, input int a1, input int a2,
                                             input int a3, input int a4);
        return {W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick_clk();
        rst = 1'b0;
        checks++; if (pwm_bus !== NEUTRAL_BUS) begin errors++; $display("FAIL reset_pwm: got %h expected %h", pwm_bus, NEUTRAL_BUS); end
        checks++; if (pwm_bus_z !== NEUTRAL_BUS) begin errors++; $display("FAIL reset_pwm_z: got %h expected %h", pwm_bus_z, NEUTRAL_BUS); end
        checks++; if (en_out !== '0) begin errors++; $display("FAIL reset_en: got %b expected 0", en_out); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err: got %b expected 0", wr_err); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", frame_tick); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", pending); end
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); end
    endtask

    // Writes in IDLE: clamp, out-of-range drop, and a write together with COMMIT.
    task automatic test_write_clamp_error();
        do_write(3'd1, 8'd250, 1'b0);
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL err_inrange: got %b expected 0", wr_err); end
        do_write(3'd5, 8'd55, 1'b0);
        checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL err_ch5: got %b expected 1", wr_err); end
        checks++; if (wr_err_z !== 1'b1) begin errors++; $display("FAIL err_ch5_z: got %b expected 1", wr_err_z); end
        tick_clk();
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %b expected 0", wr_err); end
        do_write(3'd2, 8'd108, 1'b0);
        do_write(3'd4, 8'd0, 1'b0);
        do_write(3'd7, 8'd33, 1'b0);
        checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL err_ch7: got %b expected 1", wr_err); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL pending_before_commit: got %b expected 0", pending); end
        checks++; if (pwm_bus_z !== NEUTRAL_BUS) begin errors++; $display("FAIL pwm_before_sweep: got %h expected %h", pwm_bus_z, NEUTRAL_BUS); end
        do_write(3'd0, 8'd90, 1'b1);
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL pending_after_commit: got %b expected 1", pending); end
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL err_after_ch0: got %b expected 0", wr_err); end
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL idle_hold: got %0d expected %0d", state, S_IDLE); end
    endtask

    // First frame: enable stagger plus the commit applied on the very first tick.
    task automatic test_stagger_sweep();
        int f1_slew [N];
        int f1_free [N];
        logic [N-1:0]   en_exp;
        logic [N*W-1:0] exp_slew;
        logic [N*W-1:0] exp_free;
        f1_slew = '{96, 104, 104, 100, 96};
        f1_free = '{90, 200, 108, 100, 0};
        global_en = 1'b1;
        tick_clk();
        for (int k = 0; k <= 42; k++) begin
            en_exp = '0;
            for (int i = 0; i < N; i++) begin
                if (k >= i * STAG) en_exp[i] = 1'b1;
                exp_slew[i*W +: W] = (k >= 2 + i) ? W'(f1_slew[i]) : 8'd100;
                exp_free[i*W +: W] = (k >= 2 + i) ? W'(f1_free[i]) : 8'd100;
            end
            checks++; if (en_out !== en_exp) begin errors++; $display("FAIL stagger_en k=%0d: got %b expected %b", k, en_out, en_exp); end
            checks++; if (frame_tick !== (k == 0)) begin errors++; $display("FAIL stagger_tick k=%0d: got %b expected %b", k, frame_tick, (k == 0)); end
            checks++; if (wr_ready !== (k > N)) begin errors++; $display("FAIL stagger_ready k=%0d: got %b expected %b", k, wr_ready, (k > N)); end
            if (k <= 8) begin
                checks++; if (pwm_bus !== exp_slew) begin errors++; $display("FAIL f1_pwm k=%0d: got %h expected %h", k, pwm_bus, exp_slew); end
                checks++; if (pwm_bus_z !== exp_free) begin errors++; $display("FAIL f1_pwm_z k=%0d: got %h expected %h", k, pwm_bus_z, exp_free); end
                checks++; if (pending !== (k == 0)) begin errors++; $display("FAIL f1_pending k=%0d: got %b expected %b", k, pending, (k == 0)); end
            end
            if (k == 40) begin
                checks++; if (state !== S_STAGGER) begin errors++; $display("FAIL state_stagger: got %0d expected %0d", state, S_STAGGER); end
            end
            if (k == 42) begin
                checks++; if (state !== S_RUN) begin errors++; $display("FAIL state_run: got %0d expected %0d", state, S_RUN); end
            end
            tick_clk();
        end
    endtask

    // Second frame: period check and a second slew step (lane 2 lands exactly on target).
    task automatic test_second_frame();
        int n;
        logic [N*W-1:0] exp_slew;
        logic [N*W-1:0] exp_free;
        exp_slew = pack5(92, 108, 108, 100, 92);
        exp_free = pack5(90, 200, 108, 100, 0);
        n = 0;
        while (frame_tick !== 1'b1 && n < FRAME + 100) begin
            tick_clk();
            n++;
        end
        checks++; if (n !== FRAME - 43) begin errors++; $display("FAIL frame_period: got %0d cycles expected %0d", n, FRAME - 43); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL f2_ready_tick: got %b expected 0", wr_ready); end
        checks++; if (en_out !== '1) begin errors++; $display("FAIL f2_en: got %b expected all ones", en_out); end
        for (int k = 1; k <= 6; k++) begin
            tick_clk();
            if (k == 5) begin
                checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL f2_ready_last: got %b expected 0", wr_ready); end
            end
        end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL f2_ready_after: got %b expected 1", wr_ready); end
        checks++; if (pwm_bus !== exp_slew) begin errors++; $display("FAIL f2_pwm: got %h expected %h", pwm_bus, exp_slew); end
        checks++; if (pwm_bus_z !== exp_free) begin errors++; $display("FAIL f2_pwm_z: got %h expected %h", pwm_bus_z, exp_free); end
    endtask

    task automatic test_drain();
        logic [N*W-1:0] exp_slew;
        exp_slew = pack5(90, 112, 108, 100, 88);
        global_en = 1'b0;
        tick_clk();
        checks++; if (en_out !== '0) begin errors++; $display("FAIL drain_en_entry: got %b expected 0", en_out); end
        checks++; if (state !== S_DRAIN) begin errors++; $display("FAIL drain_state_entry: got %0d expected %0d", state, S_DRAIN); end
        global_en = 1'b1;
        repeat (3) tick_clk();
        checks++; if (state !== S_DRAIN) begin errors++; $display("FAIL drain_ignores_en: got %0d expected %0d", state, S_DRAIN); end
        checks++; if (en_out !== '0) begin errors++; $display("FAIL drain_en_hold: got %b expected 0", en_out); end
        global_en = 1'b0;
        repeat (FRAME - 4) tick_clk();
        checks++; if (state !== S_DRAIN) begin errors++; $display("FAIL drain_last_cycle: got %0d expected %0d", state, S_DRAIN); end
        tick_clk();
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL drain_to_idle: got %0d expected %0d", state, S_IDLE); end
        checks++; if (pwm_bus !== exp_slew) begin errors++; $display("FAIL drain_sweep_pwm: got %h expected %h", pwm_bus, exp_slew); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", wr_ready); end
    endtask

    task automatic test_reset_mid_sweep();
        do_write(3'd3, 8'd150, 1'b1);
        global_en = 1'b1;
        tick_clk();
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL restart_tick: got %b expected 1", frame_tick); end
        commit = 1'b1;
        tick_clk();
        commit = 1'b0;
        tick_clk();
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL midsweep_pending: got %b expected 1", pending); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL midsweep_ready: got %b expected 0", wr_ready); end
        rst = 1'b1;
        global_en = 1'b0;
        tick_clk();
        checks++; if (pwm_bus !== NEUTRAL_BUS) begin errors++; $display("FAIL rst_pwm: got %h expected %h", pwm_bus, NEUTRAL_BUS); end
        checks++; if (pwm_bus_z !== NEUTRAL_BUS) begin errors++; $display("FAIL rst_pwm_z: got %h expected %h", pwm_bus_z, NEUTRAL_BUS); end
        checks++; if (en_out !== '0) begin errors++; $display("FAIL rst_en: got %b expected 0", en_out); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rst_pending: got %b expected 0", pending); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", wr_ready); end
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL rst_state: got %0d expected %0d", state, S_IDLE); end
        rst = 1'b0;
        repeat (6) tick_clk();
        checks++; if (pwm_bus_z !== NEUTRAL_BUS) begin errors++; $display("FAIL rst_no_resume: got %h expected %h", pwm_bus_z, NEUTRAL_BUS); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_tick_idle: got %b expected 0", frame_tick); end
    endtask

    initial begin
        rst       = 1'b1;
        global_en = 1'b0;
        wr_valid  = 1'b0;
        wr_ch     = '0;
        wr_data   = '0;
        commit    = 1'b0;
        test_reset();
        test_write_clamp_error();
        test_stagger_sweep();
        test_second_frame();
        test_drain();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before the end of the test sequence");
        $fatal(1, "watchdog expired");
    end

endmodule
